// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI slave.
// Holds the 3-bit state encoding, the FSM state type built on it, and the
// command-bit values that select the write or read path.
package spi_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHK_CMD   = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_READ_ADD  = 3'd3;
  localparam logic [2:0] ST_READ_DATA = 3'd4;
  localparam logic [2:0] ST_READ_TX   = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    CHK_CMD   = ST_CHK_CMD,
    WRITE     = ST_WRITE,
    READ_ADD  = ST_READ_ADD,
    READ_DATA = ST_READ_DATA,
    READ_TX   = ST_READ_TX,
    DONE      = ST_DONE
  } state_t;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

endpackage

// File: rtl/spi_slave_param_if.sv
// Bus bundle between an SPI master side and spi_slave_param.
// Carries the serial lines (SS_n, MOSI, MISO), the received word with its
// valid pulse, the read-data handshake (tx_data/tx_valid), and the
// frame_err and busy status flags.
//   slave  modport: used by spi_slave_param
//   master modport: used by whoever drives the serial side and read data
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_shift_reg.sv
// Generic load/shift/clear shift register used for both the receive and
// transmit paths of the SPI slave.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear (highest priority)
//   load       : parallel load of load_val
//   shift      : shift by one position, sin entering at the tail
//   shifted    : value the register takes on a shift; lets the owner capture
//                a completed word or the next serial bit on the same edge
// MSB_FIRST=1 shifts toward the MSB (sin enters at bit 0, bit W-1 leaves
// first); MSB_FIRST=0 shifts toward the LSB (sin enters at bit W-1).
module spi_shift_reg #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] shifted
);
  logic [W-1:0] q;

  // Shifted value in the configured direction.
  always_comb begin
    shifted = q;
    if (MSB_FIRST) begin
      shifted = {q[W-2:0], sin};
    end else begin
      shifted = {sin, q[W-1:1]};
    end
  end

  // Storage register with clear > load > shift priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shifted;
    end else begin
      q <= q;
    end
  end
endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave. Deserialises MOSI frames of one command bit
// followed by FRAME_W = DATA_W+2 bits ({sub_cmd, payload}) into rx_data with
// a one-cycle rx_valid pulse, and on a read-data frame returns tx_data on
// MISO. SS_n rising mid-frame aborts with a one-cycle frame_err pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport carrying SS_n, MOSI, MISO, rx_data, rx_valid,
//                tx_data, tx_valid, frame_err, busy
// With MSB_FIRST=0 the whole FRAME_W word travels LSB first, so the first
// received bit lands in rx_data[0] and the sub-command bits, arriving last,
// stay in the top two bits.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  spi_slave_param_if.slave bus
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(DATA_W + 1);

  state_t             cs, ns;
  logic [CNT_W-1:0]   bit_cnt;
  logic [TXC_W-1:0]   tx_cnt;
  logic               tx_active, read_sel;
  logic               miso, rx_valid, frame_err, busy;
  logic [FRAME_W-1:0] rx_data, rx_shifted;
  logic [DATA_W-1:0]  tx_shifted;
  logic               rx_shift, last_bit, abort, rx_clr;
  logic               tx_load, tx_shift, tx_done;

  // First bit to appear on MISO for a given word.
  function automatic logic lead_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  // Per-cycle control strobes; nothing is sampled while SS_n is high.
  always_comb begin
    rx_shift = 1'b0;
    abort    = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_done  = 1'b0;
    if (cs inside {WRITE, READ_ADD, READ_DATA}) begin
      rx_shift = ~bus.SS_n;
    end else begin
      rx_shift = 1'b0;
    end
    if (cs inside {CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_TX}) begin
      abort = bus.SS_n;
    end else begin
      abort = 1'b0;
    end
    if (cs == READ_TX && !bus.SS_n) begin
      tx_load  = ~tx_active & bus.tx_valid;
      tx_shift = tx_active & (tx_cnt != TXC_W'(DATA_W));
      tx_done  = tx_active & (tx_cnt == TXC_W'(DATA_W));
    end else begin
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      tx_done  = 1'b0;
    end
    last_bit = rx_shift & (bit_cnt == CNT_W'(FRAME_W - 1));
    rx_clr   = (cs == IDLE);
  end

  // Next-state logic; an abort overrides every in-frame transition.
  always_comb begin
    ns = cs;
    if (abort) begin
      ns = IDLE;
    end else begin
      case (cs)
        IDLE:      ns = bus.SS_n ? IDLE : CHK_CMD;
        CHK_CMD: begin
          if (bus.MOSI == CMD_WRITE) begin
            ns = WRITE;
          end else if (read_sel) begin
            ns = READ_DATA;
          end else begin
            ns = READ_ADD;
          end
        end
        WRITE:     ns = last_bit ? DONE : WRITE;
        READ_ADD:  ns = last_bit ? DONE : READ_ADD;
        READ_DATA: ns = last_bit ? READ_TX : READ_DATA;
        READ_TX:   ns = tx_done ? DONE : READ_TX;
        DONE:      ns = bus.SS_n ? IDLE : DONE;
        default:   ns = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs <= IDLE;
    end else begin
      cs <= ns;
    end
  end

  // Counters, received word, read-select flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
      read_sel  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bit_cnt   <= rx_shift ? bit_cnt + CNT_W'(1) : '0;
      rx_valid  <= last_bit;
      frame_err <= abort;
      busy      <= (ns != IDLE);
      tx_active <= tx_load | (tx_active & (ns == READ_TX));
      if (last_bit) begin
        rx_data <= rx_shifted;
      end else begin
        rx_data <= rx_data;
      end
      if (last_bit && cs == READ_ADD) begin
        read_sel <= 1'b1;
      end else if (tx_done) begin
        read_sel <= 1'b0;
      end else begin
        read_sel <= read_sel;
      end
      // tx_cnt counts bits already presented on MISO.
      if (tx_load) begin
        tx_cnt <= TXC_W'(1);
        miso   <= lead_bit(bus.tx_data);
      end else if (tx_shift) begin
        tx_cnt <= tx_cnt + TXC_W'(1);
        miso   <= lead_bit(tx_shifted);
      end else begin
        tx_cnt <= '0;
        miso   <= 1'b0;
      end
    end
  end

  spi_shift_reg #(.W(FRAME_W), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (rx_clr),
    .load     (1'b0),
    .load_val ({FRAME_W{1'b0}}),
    .shift    (rx_shift),
    .sin      (bus.MOSI),
    .shifted  (rx_shifted)
  );

  spi_shift_reg #(.W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (rx_clr),
    .load     (tx_load),
    .load_val (bus.tx_data),
    .shift    (tx_shift),
    .sin      (1'b0),
    .shifted  (tx_shifted)
  );

  assign bus.MISO      = miso;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;
endmodule
